reg_writeback_queue: RTL
========================

Name: reg_writeback_queue

Overview:
- Write-side front end of the 32x32 register file. It merges two writeback producers onto the file's single write port (address, data, write-enable).
- Port A is the in-order pipeline writeback (ALU/load). It has no backpressure and always wins the port.
- Port B is the long-latency unit (mul/div) writeback. It uses a valid/ready handshake and is buffered in a FIFO that drains in cycles when port A is idle.
- Also answers "is a write to register X still queued?" for the hazard/stall logic.

Parameters:
- DEPTH, 4, FIFO entries for port B; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- a_valid_i  in  1  port A write request this cycle.
- a_addr_i  in  5  port A destination register.
- a_data_i  in  32  port A write data.
- b_valid_i  in  1  port B write offered.
- b_ready_o  out  1  port B can accept this cycle.
- b_addr_i  in  5  port B destination register.
- b_data_i  in  32  port B write data.
- RDaddr_o  out  5  register file write address.
- RDdata_o  out  32  register file write data.
- RegWrite_o  out  1  register file write enable.
- rs_addr_i  in  5  lookup address 1.
- rt_addr_i  in  5  lookup address 2.
- rs_pending_o  out  1  a queued B entry targets rs_addr_i.
- rt_pending_o  out  1  a queued B entry targets rt_addr_i.
- count_o  out  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_i high, async): FIFO empty, read/write pointers 0, count_o=0, b_ready_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, pending outputs 0. All outputs are held at these values while rst_i is high, regardless of inputs.
- b_ready_o = (count != DEPTH), driven from registered count only. It does not depend on b_valid_i or a pop in the same cycle, so a full FIFO rejects a push even while popping.
- Push: b_valid_i && b_ready_o at the clock edge. Entries with b_addr_i==0 are accepted (handshake completes) but not stored.
- Output mux (combinational, zero latency):
  - a_valid_i && a_addr_i!=0: drive A's address/data, RegWrite_o=1.
  - else if FIFO non-empty: drive head entry, RegWrite_o=1, pop at the edge.
  - else RegWrite_o=0 and RDaddr_o/RDdata_o=0.
- a_valid_i with a_addr_i==0 counts as idle, so the FIFO head may drain in that cycle.
- Minimum B latency is 1 cycle: push at edge N, write visible in cycle N+1 if A is idle. Each cycle A occupies the port adds one cycle.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- Ordering: the FIFO drains strictly in order. No address-based reordering and no merging. WAW between A and B is prevented by the stall logic using the pending outputs.
- Pending lookup: OR over valid entries of (entry addr == lookup addr). The entry being popped this cycle still reports pending; it is written this cycle, and the register file bypass covers the read. Lookup address 0 always returns 0.
- Reset asserted mid-operation discards all queued entries, with no partial write.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined: when the FIFO is empty, port A is idle (per the rule above), and B completes a handshake with a nonzero address, the B write is driven to the outputs in the same cycle and is not enqueued. Latency is 0.
- Undefined: every B write is enqueued; minimum latency is 1 cycle.
- Both builds: b_ready_o is unchanged (no combinational path from b_valid_i).

Test Plan:
1. Reset: assert rst_i mid-cycle with 3 entries queued -> count_o=0, RegWrite_o=0, b_ready_o=0 immediately; after release, b_ready_o=1 and no stale write appears.
2. B alone: push (r5, 0xDEADBEEF) with A idle -> next cycle RDaddr_o=5, RDdata_o=0xDEADBEEF, RegWrite_o=1, count_o returns to 0. With WBQ_BYPASS_EN: the write appears in the push cycle and count_o stays 0.
3. Priority: queue (r7, 0x11); hold A valid to (r3, 0x22) for 3 cycles -> three r3 writes, then r7 written in cycle 4; rs_addr_i=7 gives rs_pending_o=1 until after that write.
4. Full: DEPTH=4, A busy, push 4 entries -> count_o=4, b_ready_o=0; a 5th offer is held and not lost; after A goes idle, drain order matches push order and the 5th is accepted once count_o=3.
5. r0 filtering: B pushes r0, and A writes r0 while the FIFO holds (r9, 0x5) -> r0 never sees RegWrite_o; r9 drains in the A-r0 cycle.
6. Wrap: 10 push/pop pairs in consecutive cycles with A idle -> pointers wrap, data order preserved, count_o stable at 1.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: merges in-order writeback (A) and buffered long-latency writeback (B) onto one RF write port.
// Optional same-cycle B bypass when queue empty and A idle: define WBQ_BYPASS_EN.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_valid_i,
    input  logic [4:0]    a_addr_i,
    input  logic [31:0]   a_data_i,
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic [4:0]    b_addr_i,
    input  logic [31:0]   b_data_i,
    output logic [4:0]    RDaddr_o,
    output logic [31:0]   RDdata_o,
    output logic          RegWrite_o,
    input  logic [4:0]    rs_addr_i,
    input  logic [4:0]    rt_addr_i,
    output logic          rs_pending_o,
    output logic          rt_pending_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic a_win;
    logic empty;
    logic b_fire;
    logic bypass;
    logic pop;
    logic push;

    assign a_win     = a_valid_i && (a_addr_i != 5'd0);
    assign empty     = (count == '0);
    assign b_ready_o = !rst_i && (count != FULL);
    assign b_fire    = b_valid_i && b_ready_o && (b_addr_i != 5'd0);
`ifdef WBQ_BYPASS_EN
    assign bypass    = b_fire && empty && !a_win;
`else
    assign bypass    = 1'b0;
`endif
    assign pop       = !rst_i && !a_win && !empty;
    assign push      = b_fire && !bypass;
    assign count_o   = count;

    // Write-port mux: A wins, then queue head, then (optionally) bypassed B.
    always_comb begin
        RDaddr_o   = 5'd0;
        RDdata_o   = 32'd0;
        RegWrite_o = 1'b0;
        if (rst_i) begin
            RegWrite_o = 1'b0;
        end else if (a_win) begin
            RDaddr_o   = a_addr_i;
            RDdata_o   = a_data_i;
            RegWrite_o = 1'b1;
        end else if (!empty) begin
            RDaddr_o   = addr_q[rd_ptr];
            RDdata_o   = data_q[rd_ptr];
            RegWrite_o = 1'b1;
        end else if (bypass) begin
            RDaddr_o   = b_addr_i;
            RDdata_o   = b_data_i;
            RegWrite_o = 1'b1;
        end
    end

    // Hazard lookup over all live entries, including the one being popped.
    always_comb begin
        rs_pending_o = 1'b0;
        rt_pending_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && addr_q[i] == rs_addr_i) rs_pending_o = 1'b1;
            if (vld_q[i] && addr_q[i] == rt_addr_i) rt_pending_o = 1'b1;
        end
        if (rst_i || rs_addr_i == 5'd0) rs_pending_o = 1'b0;
        if (rst_i || rt_addr_i == 5'd0) rt_pending_o = 1'b0;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
            vld_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (push) begin
                addr_q[wr_ptr] <= b_addr_i;
                data_q[wr_ptr] <= b_data_i;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

endmodule
